// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scancode receiver.
// Holds prefix bytes, bytes that never produce a key event, and the frame FSM type.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam int unsigned PS2_FRAME_BITS = 11;

   localparam logic [7:0] PS2_ERR_00  = 8'h00;
   localparam logic [7:0] PS2_ERR_FF  = 8'hFF;
   localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
   localparam logic [7:0] PS2_ACK     = 8'hFA;
   localparam logic [7:0] PS2_RESEND  = 8'hFE;
   localparam logic [7:0] PS2_ECHO    = 8'hEE;
   localparam logic [7:0] PS2_PAUSE   = 8'hE1;

   typedef enum logic {
      IDLE,
      RX
   } frame_state_e;

   function automatic logic is_ignored(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      case (b)
         PS2_ERR_00, PS2_ERR_FF, PS2_BAT_OK, PS2_ACK,
         PS2_RESEND, PS2_ECHO, PS2_PAUSE: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and 11-bit frame receiver with parity, stop and timeout checks.
// Emits a byte strobe for good frames and an error strobe for bad or truncated ones.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
   logic                   clk_s, dat_s;
   logic                   filt_q, filt_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   sample;

   frame_state_e  state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          bv_q, bv_d;
   logic          fe_q, fe_d;

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   // The filtered clock only moves after FILTER_LEN agreeing samples; a move to 0 is a sample.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      sample = 1'b0;
      if (clk_s != filt_q) begin
         if (fcnt_q == FILT_LAST) begin
            filt_d = clk_s;
            sample = filt_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tmo_d    = tmo_q;
      bv_d     = 1'b0;
      fe_d     = 1'b0;

      // A sample event always beats a coincident timeout.
      if (sample) begin
         tmo_d = '0;
      end else if (state_q == RX) begin
         if (tmo_q == TMO_MAX) begin
            state_d = IDLE;
            fe_d    = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end else begin
         tmo_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (sample && !dat_s) begin
               state_d  = RX;
               bitcnt_d = 4'd1;
            end
         end
         RX: begin
            if (sample) begin
               if (bitcnt_q <= 4'd8) begin
                  shift_d = {dat_s, shift_q[7:1]};
               end else if (bitcnt_q == 4'd9) begin
                  par_d = dat_s;
               end
               if (bitcnt_q == LAST_BIT) begin
                  state_d = IDLE;
                  if (((^shift_q) ^ par_q) && dat_s) begin
                     bv_d = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tmo_q      <= '0;
         bv_q       <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tmo_q      <= tmo_d;
         bv_q       <= bv_d;
         fe_q       <= fe_d;
      end
   end

   assign byte_o       = shift_q;
   assign byte_valid_o = bv_q;
   assign frame_err_o  = fe_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: frame receiver plus F0/E0 prefix tracking.
// Presents a held keycode with make/break and extended flags and a one-cycle update strobe.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] keycode,
   output logic       press,
   output logic       extended,
   output logic       key_valid,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic [7:0] keycode_q, keycode_d;
   logic       press_q, press_d;
   logic       extended_q, extended_d;
   logic       key_valid_q, key_valid_d;

   ps2_rx_frame #(
      .SYNC_STAGES    (SYNC_STAGES),
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i        (Clk),
      .rst_ni       (Reset_n),
      .ps2_clk_i    (PS2_CLK),
      .ps2_dat_i    (PS2_DAT),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_err)
   );

   always_comb begin
      brk_d       = brk_q;
      ext_d       = ext_q;
      keycode_d   = keycode_q;
      press_d     = press_q;
      extended_d  = extended_q;
      key_valid_d = 1'b0;
      if (rx_err) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == PS2_BREAK) begin
            brk_d = 1'b1;
         end else if (is_ignored(rx_byte)) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else begin
            keycode_d   = rx_byte;
            press_d     = ~brk_q;
            extended_d  = ext_q;
            key_valid_d = 1'b1;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         keycode_q   <= 8'h00;
         press_q     <= 1'b0;
         extended_q  <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         keycode_q   <= keycode_d;
         press_q     <= press_d;
         extended_q  <= extended_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign keycode   = keycode_q;
   assign press     = press_q;
   assign extended  = extended_q;
   assign key_valid = key_valid_q;
   assign frame_err = rx_err;

endmodule
